// File: rtl/ahb_subordinate_memory.sv
// AHB subordinate backed by a local byte-addressable memory.
// Every transfer gets a programmable number of wait states, or the
// two-cycle ERROR response when it is out of range, oversized or misaligned.
module ahb_subordinate_memory #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = {ADDR_WIDTH{1'b0}},
  parameter int                    WAIT_WIDTH    = 4
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  input  logic [WAIT_WIDTH-1:0]   wait_states,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(STRB_WIDTH);
  localparam int WORD_BITS  = MEM_ADDR_BITS - LANE_BITS;
  localparam int DEPTH      = 1 << WORD_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [WAIT_WIDTH-1:0] r_waitCnt;
  logic [WAIT_WIDTH-1:0] w_nextWaitCnt;
  logic [WORD_BITS-1:0]  r_wordIdx;
  logic                  r_write;
  logic [STRB_WIDTH-1:0] r_laneMask;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_canAccept;
  logic                  w_accept;
  logic                  w_inRange;
  logic                  w_sizeErr;
  logic                  w_misaligned;
  logic                  w_error;
  logic [STRB_WIDTH-1:0] w_laneMask;
  logic [WORD_BITS-1:0]  w_addrIdx;
  logic                  w_commit;
  logic [STRB_WIDTH-1:0] w_wrMask;
  logic [WORD_BITS-1:0]  w_rdIdx;
  logic [DATA_WIDTH-1:0] w_rdWord;
  logic                  w_loadRead;
  logic                  w_unused;

  // Protection, burst type and the BUSY/IDLE distinction carry no meaning here.
  assign w_unused = ^{hburst, hprot, htrans[0]};

  assign w_inRange = (haddr[ADDR_WIDTH-1:MEM_ADDR_BITS] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_BITS]);
  assign w_sizeErr = (int'(hsize) > LANE_BITS);
  assign w_error   = !w_inRange || w_sizeErr || w_misaligned;
  assign w_addrIdx = haddr[MEM_ADDR_BITS-1:LANE_BITS];

  // Byte lanes covered by the addressed size, and whether the address breaks size alignment.
  always_comb begin
    w_laneMask   = '0;
    w_misaligned = 1'b0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if ((i >= int'(haddr[LANE_BITS-1:0])) &&
          (i < int'(haddr[LANE_BITS-1:0]) + (1 << hsize))) begin
        w_laneMask[i] = 1'b1;
      end
    end
    for (int i = 0; i < LANE_BITS; i++) begin
      if ((i < int'(hsize)) && haddr[i]) begin
        w_misaligned = 1'b1;
      end
    end
  end

  // Next-state, wait counter and bus response decode; ready states also accept a new address phase.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_canAccept   = 1'b0;
    hreadyout     = 1'b1;
    hresp         = 1'b0;
    case (r_state)
      ST_IDLE, ST_OKAY, ST_ERR2: begin
        hreadyout   = 1'b1;
        hresp       = (r_state == ST_ERR2);
        w_canAccept = 1'b1;
        w_nextState = ST_IDLE;
        if (hsel && hready && htrans[1]) begin
          if (w_error) begin
            w_nextState = ST_ERR1;
          end else if (wait_states == '0) begin
            w_nextState = ST_OKAY;
          end else begin
            w_nextState   = ST_WAIT;
            w_nextWaitCnt = wait_states;
          end
        end
      end
      ST_WAIT: begin
        hreadyout     = 1'b0;
        hresp         = 1'b0;
        w_nextWaitCnt = r_waitCnt - 1'b1;
        if (r_waitCnt <= 1) begin
          w_nextState = ST_OKAY;
        end
      end
      ST_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = 1'b1;
        w_nextState = ST_ERR2;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign w_accept = w_canAccept && hsel && hready;
  assign w_commit = (r_state == ST_OKAY) && r_write;
  assign w_wrMask = hwstrb & r_laneMask;
  assign w_rdIdx  = (r_state == ST_WAIT) ? r_wordIdx : w_addrIdx;
  assign w_loadRead = (w_nextState == ST_OKAY) &&
                      ((r_state == ST_WAIT) ? !r_write : !hwrite);

  // Read word for the next data phase, merging bytes of a write that commits on the same edge.
  always_comb begin
    w_rdWord = r_mem[w_rdIdx];
    if (w_commit && (w_rdIdx == r_wordIdx)) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_wrMask[i]) begin
          w_rdWord[8*i +: 8] = hwdata[8*i +: 8];
        end
      end
    end
  end

  // Memory array is never reset; writes land at the end of the completing data-phase cycle.
  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_wrMask[i]) begin
          r_mem[r_wordIdx][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // State, counter, captured address phase and registered read data.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= ST_IDLE;
      r_waitCnt  <= '0;
      r_wordIdx  <= '0;
      r_write    <= 1'b0;
      r_laneMask <= '0;
      r_hrdata   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_accept) begin
        r_wordIdx  <= w_addrIdx;
        r_write    <= hwrite && htrans[1] && !w_error;
        r_laneMask <= w_laneMask;
      end
      if (w_loadRead) begin
        r_hrdata <= w_rdWord;
      end
    end
  end

  assign hrdata = r_hrdata;

endmodule
